encoder_4to2: RTL and testbench

- Registered 4-to-2 binary encoder. Four one-hot request lines D0..D3 are encoded to a 2-bit index {x,y}.
- Adds priority resolution for multi-hot inputs, a valid flag and a multi-hot error flag.
- Used wherever a one-hot select or request vector must be compressed to a binary index with a one-cycle registered output.

---
 rtl/encoder_pkg.sv | 18 +
 rtl/encoder_4to2_core.sv | 24 ++
 rtl/encoder_4to2.sv | 39 +++
 tb/tb_encoder_4to2.sv | 121 ++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared widths, index constants and result payload for the 4-to-2 encoder.
package encoder_pkg;

  localparam int unsigned IDX_W = 2;
  localparam int unsigned N_IN  = 4;

  localparam logic [IDX_W-1:0] IDX_D0 = 2'b00;
  localparam logic [IDX_W-1:0] IDX_D1 = 2'b01;
  localparam logic [IDX_W-1:0] IDX_D2 = 2'b10;
  localparam logic [IDX_W-1:0] IDX_D3 = 2'b11;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             any;
    logic             multi;
  } enc_res_t;

endpackage

// File: rtl/encoder_4to2_core.sv
// Combinational priority encoder: highest set request wins, plus any/multi flags.
module encoder_4to2_core
  import encoder_pkg::*;
(
  input  logic [N_IN-1:0] i_req,
  output enc_res_t        o_res_c
);

  always_comb begin
    o_res_c = '0;
    if (i_req[3])      o_res_c.idx = IDX_D3;
    else if (i_req[2]) o_res_c.idx = IDX_D2;
    else if (i_req[1]) o_res_c.idx = IDX_D1;
    else               o_res_c.idx = IDX_D0;
    o_res_c.any = |i_req;
    // Any pair of simultaneously set requests means multi-hot.
    for (int i = 0; i < int'(N_IN); i++) begin
      for (int j = i + 1; j < int'(N_IN); j++) begin
        o_res_c.multi = o_res_c.multi | (i_req[i] & i_req[j]);
      end
    end
  end

endmodule

// File: rtl/encoder_4to2.sv
// Registered 4-to-2 priority encoder with valid and multi-hot error flags.
module encoder_4to2
  import encoder_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic D0,
  input  logic D1,
  input  logic D2,
  input  logic D3,
  output logic x,
  output logic y,
  output logic valid,
  output logic multi_err
);

  logic [N_IN-1:0] w_req;
  enc_res_t        w_res;
  enc_res_t        r_res;

  assign w_req = {D3, D2, D1, D0};

  encoder_4to2_core u_core (
    .i_req   (w_req),
    .o_res_c (w_res)
  );

  // Synchronous reset discards the inputs sampled on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) r_res <= '0;
    else        r_res <= w_res;
  end

  assign x         = r_res.idx[1];
  assign y         = r_res.idx[0];
  assign valid     = r_res.any;
  assign multi_err = r_res.multi;

endmodule

// File: tb/tb_encoder_4to2.sv
// Scoreboard bench for encoder_4to2: directed plan, exhaustive sweep, random stream.
module tb_encoder_4to2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic D0 = 1'b1, D1 = 1'b1, D2 = 1'b1, D3 = 1'b1;
  logic x, y, valid, multi_err;

  int    checks = 0;
  int    failures = 0;
  bit    run = 1'b1;
  string cur_tag = "reset_hold";

  logic [3:0] q_exp[$];
  string      q_tag[$];

  encoder_4to2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .D0        (D0),
    .D1        (D1),
    .D2        (D2),
    .D3        (D3),
    .x         (x),
    .y         (y),
    .valid     (valid),
    .multi_err (multi_err)
  );

  always #5 clk = ~clk;

  // Reference: {x,y,valid,multi_err} from highest set index and popcount.
  function automatic logic [3:0] ref_model(input logic rst, input logic [3:0] d);
    int hi;
    int cnt;
    hi = 0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (d[i]) begin
        hi = i;
        cnt = cnt + 1;
      end
    end
    if (!rst) return 4'b0000;
    return {2'(hi), (cnt >= 1), (cnt >= 2)};
  endfunction

  // Stimulus side of the scoreboard: record what each edge should produce.
  always @(posedge clk) begin
    if (run) begin
      q_exp.push_back(ref_model(rst_n, {D3, D2, D1, D0}));
      q_tag.push_back(cur_tag);
    end
  end

  // Monitor: outputs are sampled shortly after every active edge.
  always @(posedge clk) begin
    logic [3:0] e;
    string      t;
    #1;
    if (q_exp.size() != 0) begin
      e = q_exp.pop_front();
      t = q_tag.pop_front();
      checks++;
      if ({x, y, valid, multi_err} !== e) begin
        failures++;
        $display("FAIL %s: got x,y,valid,multi_err=%b expected %b", t,
                 {x, y, valid, multi_err}, e);
      end
    end
  end

  task automatic apply(input logic r, input logic [3:0] d, input string tag);
    @(negedge clk);
    rst_n = r;
    {D3, D2, D1, D0} = d;
    cur_tag = tag;
  endtask

  initial begin
    logic [3:0] rd;
    // Reset held for two edges with all requests high, then released.
    apply(1'b0, 4'b1111, "reset_hold0");
    apply(1'b0, 4'b1111, "reset_hold1");
    apply(1'b1, 4'b1111, "reset_release");
    // One-hot sweep.
    apply(1'b1, 4'b0001, "onehot_d0");
    apply(1'b1, 4'b0010, "onehot_d1");
    apply(1'b1, 4'b0100, "onehot_d2");
    apply(1'b1, 4'b1000, "onehot_d3");
    // All-zero versus D0.
    apply(1'b1, 4'b0000, "all_zero");
    apply(1'b1, 4'b0001, "d0_vs_zero");
    // Multi-hot priority.
    apply(1'b1, 4'b0110, "multi_0110");
    apply(1'b1, 4'b0011, "multi_0011");
    apply(1'b1, 4'b1001, "multi_1001");
    // Mid-stream reset pulse with D2 held.
    apply(1'b0, 4'b0100, "midreset_pulse");
    apply(1'b1, 4'b0100, "midreset_after");
    // Exhaustive in consecutive cycles.
    for (int i = 0; i < 16; i++) apply(1'b1, 4'(i), "exhaustive");
    // Random stream with occasional reset.
    for (int i = 0; i < 300; i++) begin
      rd = 4'($urandom_range(0, 15));
      apply(($urandom_range(0, 15) != 0), rd, "random");
    end
    @(negedge clk);
    run = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (q_exp.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q_exp.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
